// File: rtl/sillyfunction_pkg.sv
// Shared types and constants for the sillyfunction on-board checker.
// SF_GOLDEN bit i is the expected y for stimulus {a,b,c} == i.
package sillyfunction_pkg;

    localparam int unsigned SF_VEC_W = 3;
    localparam logic [7:0] SF_GOLDEN = 8'b0011_0001;

    typedef enum logic [1:0] {
        StIdle,
        StApply,
        StDone
    } sf_state_e;

endpackage

// File: rtl/sillyfunction_golden.sv
// Combinational golden lookup: vector index to expected DUT response.
// TABLE defaults to sillyfunction; override it to check a different 3-input function.
module sillyfunction_golden
    import sillyfunction_pkg::*;
#(
    parameter logic [7:0] TABLE = SF_GOLDEN
) (
    input  logic [SF_VEC_W-1:0] idx,
    output logic                y
);

    assign y = TABLE[idx];

endmodule

// File: rtl/sillyfunction_checker.sv
// Self-checking harness: sweeps every {a,b,c} into the DUT, samples y after a settle
// window, and accumulates an error count, the first failing index and a pass flag.
module sillyfunction_checker
    import sillyfunction_pkg::*;
#(
    parameter int unsigned SETTLE = 2,
    parameter int unsigned NVEC   = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    output logic       dut_a,
    output logic       dut_b,
    output logic       dut_c,
    input  logic       dut_y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [2:0] fail_idx
);

    localparam logic [3:0]          SETTLE_CNT = 4'(SETTLE);
    localparam logic [SF_VEC_W-1:0] LAST_IDX   = SF_VEC_W'(NVEC - 1);

    sf_state_e           state;
    logic [SF_VEC_W-1:0] idx;
    logic [3:0]          settle_cnt;
    logic                first_fail;
    logic                expected;

    sillyfunction_golden u_golden (
        .idx (idx),
        .y   (expected)
    );

    // idx is a register and holds the last vector in StDone, so the stimulus stays registered.
    assign {dut_a, dut_b, dut_c} = idx;
    assign pass = done & (err_count == 4'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= StIdle;
            idx        <= '0;
            settle_cnt <= '0;
            err_count  <= '0;
            fail_idx   <= '0;
            first_fail <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            unique case (state)
                StIdle, StDone: begin
                    if (start) begin
                        state      <= StApply;
                        idx        <= '0;
                        settle_cnt <= '0;
                        err_count  <= '0;
                        fail_idx   <= '0;
                        first_fail <= 1'b0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                    end
                end
                StApply: begin
                    if (settle_cnt == SETTLE_CNT) begin
                        settle_cnt <= '0;
                        if (dut_y != expected) begin
                            err_count <= err_count + 4'd1;
                            if (!first_fail) begin
                                fail_idx   <= idx;
                                first_fail <= 1'b1;
                            end
                        end
                        if (idx == LAST_IDX) begin
                            state <= StDone;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sillyfunction_checker.sv
// Directed bench for sillyfunction_checker: behavioural DUT models selected by mode,
// default-timing instance plus a SETTLE=0 instance.
module tb_sillyfunction_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n, start0, start1;
    logic       a0, b0, c0, y0, busy0, done0, pass0;
    logic       a1, b1, c1, y1, busy1, done1, pass1;
    logic [3:0] err0, err1;
    logic [2:0] fidx0, fidx1;

    // 0 = correct sillyfunction, 1 = tied 0, 2 = tied 1, 3 = inverted
    int mode;
    int checks   = 0;
    int failures = 0;
    int cyc;

    function automatic logic dut_model(input int m, input logic a, input logic b, input logic c);
        logic good;
        good = (~b & ~c) | (a & ~b);
        case (m)
            0:       return good;
            1:       return 1'b0;
            2:       return 1'b1;
            default: return ~good;
        endcase
    endfunction

    always_comb y0 = dut_model(mode, a0, b0, c0);
    always_comb y1 = dut_model(mode, a1, b1, c1);

    sillyfunction_checker #(.SETTLE(2), .NVEC(8)) u_chk0 (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start0),
        .dut_a     (a0),
        .dut_b     (b0),
        .dut_c     (c0),
        .dut_y     (y0),
        .busy      (busy0),
        .done      (done0),
        .pass      (pass0),
        .err_count (err0),
        .fail_idx  (fidx0)
    );

    sillyfunction_checker #(.SETTLE(0), .NVEC(8)) u_chk1 (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start1),
        .dut_a     (a1),
        .dut_b     (b1),
        .dut_c     (c1),
        .dut_y     (y1),
        .busy      (busy1),
        .done      (done1),
        .pass      (pass1),
        .err_count (err1),
        .fail_idx  (fidx1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse0();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
    endtask

    // Called just after the start edge; returns edges until done0 (bounded).
    task automatic run0(input string tag, input bit check_vec, output int cycles);
        cycles = 0;
        while (!done0 && cycles < 200) begin
            if (check_vec) begin
                check({tag, "_vec"}, {29'd0, a0, b0, c0}, cycles / 3);
                check({tag, "_busy"}, busy0, 1);
            end
            tick();
            cycles++;
        end
    endtask

    task automatic run1(output int cycles);
        cycles = 0;
        while (!done1 && cycles < 200) begin
            tick();
            cycles++;
        end
    endtask

    int exp_err[3]  = '{3, 5, 8};
    int exp_fidx[3] = '{0, 1, 0};

    initial begin
        reset_n = 1'b0;
        start0  = 1'b0;
        start1  = 1'b0;
        mode    = 0;
        repeat (2) tick();
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_pass", pass0, 0);
        check("rst_err", err0, 0);
        check("rst_fidx", fidx0, 0);
        check("rst_vec", {a0, b0, c0}, 0);
        check("rst_done1", done1, 0);
        reset_n = 1'b1;
        tick();
        check("idle_busy", busy0, 0);

        // Correct DUT: 24-cycle run, stimulus ascending, 3 cycles per vector
        start_pulse0();
        run0("good", 1'b1, cyc);
        check("good_cycles", cyc, 24);
        check("good_done", done0, 1);
        check("good_busy", busy0, 0);
        check("good_pass", pass0, 1);
        check("good_err", err0, 0);
        check("good_fidx", fidx0, 0);
        check("good_lastvec", {a0, b0, c0}, 7);
        repeat (3) tick();
        check("good_hold_done", done0, 1);
        check("good_hold_pass", pass0, 1);

        // Faulty DUT models
        for (int m = 1; m <= 3; m++) begin
            mode = m;
            start_pulse0();
            run0("fault", 1'b0, cyc);
            check("fault_cycles", cyc, 24);
            check("fault_err", err0, exp_err[m-1]);
            check("fault_fidx", fidx0, exp_fidx[m-1]);
            check("fault_pass", pass0, 0);
        end

        // Start re-pulsed mid-run is ignored
        mode = 2;
        start_pulse0();
        repeat (9) tick();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        check("ign_busy", busy0, 1);
        check("ign_vec", {a0, b0, c0}, 3);
        run0("ign", 1'b0, cyc);
        check("ign_cycles", cyc + 10, 24);
        check("ign_err", err0, 5);
        check("ign_fidx", fidx0, 1);

        // Second start from DONE clears and repeats
        start_pulse0();
        check("rerun_clr_err", err0, 0);
        check("rerun_clr_fidx", fidx0, 0);
        check("rerun_clr_done", done0, 0);
        check("rerun_busy", busy0, 1);
        run0("rerun", 1'b0, cyc);
        check("rerun_cycles", cyc, 24);
        check("rerun_err", err0, 5);
        check("rerun_fidx", fidx0, 1);

        // Reset mid-run
        mode = 1;
        start_pulse0();
        repeat (12) tick();
        check("abort_pre_err", err0, 1);
        reset_n = 1'b0;
        #1;
        check("abort_async_busy", busy0, 0);
        check("abort_async_err", err0, 0);
        repeat (2) tick();
        check("abort_busy", busy0, 0);
        check("abort_done", done0, 0);
        check("abort_pass", pass0, 0);
        check("abort_fidx", fidx0, 0);
        check("abort_vec", {a0, b0, c0}, 0);
        reset_n = 1'b1;
        repeat (2) tick();
        check("abort_idle", busy0, 0);
        mode = 0;
        start_pulse0();
        run0("after_abort", 1'b0, cyc);
        check("after_abort_cycles", cyc, 24);
        check("after_abort_pass", pass0, 1);

        // Start held high loops runs back to back
        start0 = 1'b1;
        tick();
        run0("loop", 1'b0, cyc);
        check("loop_cycles", cyc, 24);
        check("loop_done", done0, 1);
        tick();
        check("loop_restart_busy", busy0, 1);
        check("loop_restart_done", done0, 0);
        start0 = 1'b0;
        run0("loop2", 1'b0, cyc);
        check("loop2_cycles", cyc, 24);
        check("loop2_pass", pass0, 1);

        // SETTLE = 0 instance
        mode = 0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("s0_busy", busy1, 1);
        check("s0_vec0", {a1, b1, c1}, 0);
        tick();
        check("s0_vec1", {a1, b1, c1}, 1);
        run1(cyc);
        check("s0_cycles", cyc + 1, 8);
        check("s0_pass", pass1, 1);
        check("s0_err", err1, 0);
        mode = 3;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        run1(cyc);
        check("s0_inv_cycles", cyc, 8);
        check("s0_inv_err", err1, 8);
        check("s0_inv_pass", pass1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
